fifo_write_arbiter: RTL and testbench

Round-robin arbiter that shares the writer port of one `async_fifo` instance between `NUM_REQ` requesters in the same clock domain. Each requester offers beats over a valid/ready handshake. The arbiter grants one requester at a time and holds the grant until that requester's packet ends. Beats pass through a one-entry output register that drives the FIFO's `writer_d_i` and `writer_enq_i` and honours `writer_full_o`.

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/fifo_write_arbiter_rr_picker.sv | 39 +++
 rtl/fifo_write_arbiter.sv | 140 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// ----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and helpers for the FIFO write arbiter.
//   arb_state_t : two-state arbitration FSM (IDLE picks a winner, GRANT
//                 streams the winner's beats into the output register).
//   rr_next     : wrap-around increment used to advance the round-robin
//                 pointer past the requester that just finished.
// ----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Returns ptr + 1, wrapping to 0 when the result reaches n.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search: returns the first set bit of the request
// vector at or after the pointer, searching upward with wrap-around.
// Ports:
//   req     in   NUM_REQ           request (valid) vector
//   ptr     in   $clog2(NUM_REQ)   index where the search starts
//   win_idx out  $clog2(NUM_REQ)   winning index (0 when nothing is requested)
//   found   out  1                 at least one request bit is set
// ----------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] win_idx,
    output logic                       found
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // NOTE: every output gets a default before the loop so no path through
    // the block leaves a variable unassigned, which would infer a latch.
    always_comb begin
        int cand;
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            // The first hit in search order wins; later hits are ignored.
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_write_arbiter
// Round-robin arbiter sharing one async_fifo writer port between NUM_REQ
// same-clock requesters. A requester keeps the grant until its packet ends;
// beats pass through a one-entry output register feeding the FIFO.
//
// Build option:
//   FIFO_ARB_BURST_EN  defined   : packet mode, grant held until req_last_i.
//                      undefined : req_last_i ignored, every beat is a packet
//                                  (per-beat round-robin).
//
// Ports:
//   clk          in   1                   clock (FIFO writer clock)
//   rst_i        in   1                   asynchronous active-high reset
//   req_valid_i  in   NUM_REQ             per-requester beat valid
//   req_last_i   in   NUM_REQ             last beat of packet
//   req_data_i   in   NUM_REQ*DATA_WIDTH  flattened beats, k at [k*DW +: DW]
//   req_ready_o  out  NUM_REQ             one-hot or zero beat accept
//   fifo_d_o     out  DATA_WIDTH          to FIFO writer_d_i
//   fifo_enq_o   out  1                   to FIFO writer_enq_i
//   fifo_full_i  in   1                   from FIFO writer_full_o
//   grant_o      out  $clog2(NUM_REQ)     current / last granted requester
//   busy_o       out  1                   in GRANT or output register full
// ----------------------------------------------------------------------------
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         fifo_d_o,
    output logic                          fifo_enq_o,
    input  logic                          fifo_full_i,
    output logic [$clog2(NUM_REQ)-1:0]    grant_o,
    output logic                          busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t            state_q;
    logic [IDX_W-1:0]      rr_ptr_q;
    logic [IDX_W-1:0]      grant_q;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_found;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_ready;
    logic                  drain;
    logic                  accept;
    logic                  beat_last;
    logic [DATA_WIDTH-1:0] grant_data;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req     (req_valid_i),
        .ptr     (rr_ptr_q),
        .win_idx (pick_idx),
        .found   (pick_found)
    );

    // The register can take a beat when empty, or when its current beat
    // leaves for the FIFO on this same edge.
    assign out_ready  = !out_valid_q || !fifo_full_i;
    assign drain      = out_valid_q && !fifo_full_i;
    assign grant_data = req_data_i[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign accept     = (state_q == GRANT) && req_valid_i[grant_q] && out_ready;

`ifdef FIFO_ARB_BURST_EN
    assign beat_last = req_last_i[grant_q];
`else
    // Every beat closes its own packet, so the last flags carry no meaning.
    logic unused_last;
    assign unused_last = ^req_last_i;
    assign beat_last   = 1'b1;
`endif

    always_comb begin
        req_ready_o = '0;
        if (state_q == GRANT) begin
            req_ready_o[grant_q] = out_ready;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    // A stalled owner (valid low) simply keeps the grant.
                    if (accept && beat_last) begin
                        rr_ptr_q <= IDX_W'(rr_next(32'(grant_q), NUM_REQ));
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the data register is reset too, so fifo_d_o reads 0 out of reset
    // and a beat caught by reset can never reappear on the bus.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= grant_data;
            end else if (drain) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign fifo_enq_o = drain;
    assign fifo_d_o   = out_data_q;
    assign grant_o    = grant_q;
    assign busy_o     = (state_q == GRANT) || out_valid_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_write_arbiter
// Self-checking bench. Requesters are modelled as per-requester beat queues;
// a reference model (owner / pointer / held-beat queue) predicts every output
// each cycle, and directed scenarios check the enqueued stream end to end.
// Expectations follow FIFO_ARB_BURST_EN when it is defined for the build.
// ----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_last_i;
    logic [N*DW-1:0] req_data_i;
    logic [N-1:0]    req_ready_o;
    logic [DW-1:0]   fifo_d_o;
    logic            fifo_enq_o;
    logic            fifo_full_i;
    logic [IW-1:0]   grant_o;
    logic            busy_o;

    fifo_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_last_i  (req_last_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .fifo_d_o    (fifo_d_o),
        .fifo_enq_o  (fifo_enq_o),
        .fifo_full_i (fifo_full_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef FIFO_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    // Requester side: pending beats stored as {last, data}.
    logic [DW:0]   pq [N][$];
    logic [N-1:0]  stall;
    logic [DW-1:0] seen [$];
    int            seen_cyc [$];
    int            cyc = 0;

    // Reference model: who owns the port (-1 = arbitrating), where the next
    // search starts, last grant shown, and the beat waiting for the FIFO.
    int            m_owner;
    int            m_ptr;
    int            m_grant;
    logic [DW-1:0] m_held [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_grant = 0;
        m_held.delete();
        for (int k = 0; k < N; k++) pq[k].delete();
        stall       = '0;
        fifo_full_i = 1'b0;
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int k = 0; k < N; k++) if (pq[k].size() != 0) p = 1'b1;
        return p || (m_held.size() != 0) || (m_owner >= 0);
    endfunction

    task automatic push(input int k, input logic last, input logic [DW-1:0] d);
        pq[k].push_back({last, d});
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (pq[k].size() != 0) begin
                req_valid_i[k]             = !stall[k];
                req_last_i[k]              = pq[k][0][DW];
                req_data_i[k*DW +: DW]     = pq[k][0][DW-1:0];
            end else begin
                req_valid_i[k]             = 1'b0;
                req_last_i[k]              = 1'($urandom);
                req_data_i[k*DW +: DW]     = $urandom;
            end
        end
    endtask

    // One clock: drive after the falling edge, check outputs before the
    // rising edge, then advance the model and the requester queues.
    task automatic cycle();
        logic         out_rdy;
        logic         e_enq;
        logic [N-1:0] e_rdy;
        logic         lastb;
        bit           hit;
        drive();
        #1;
        out_rdy = (m_held.size() == 0) || !fifo_full_i;
        e_enq   = (m_held.size() != 0) && !fifo_full_i;
        e_rdy   = '0;
        if (m_owner >= 0) e_rdy[m_owner] = out_rdy;
        chk("req_ready", 64'(req_ready_o), 64'(e_rdy));
        chk("fifo_enq",  64'(fifo_enq_o),  64'(e_enq));
        chk("grant",     64'(grant_o),     64'(m_grant));
        chk("busy",      64'(busy_o),      64'((m_owner >= 0) || (m_held.size() != 0)));
        if (e_enq) chk("fifo_d", 64'(fifo_d_o), 64'(m_held[0]));
        if (fifo_enq_o) begin
            seen.push_back(fifo_d_o);
            seen_cyc.push_back(cyc);
        end
        if (e_enq) void'(m_held.pop_front());
        if (m_owner < 0) begin
            hit = 1'b0;
            for (int i = 0; i < N; i++) begin
                int k = (m_ptr + i) % N;
                if (!hit && req_valid_i[k]) begin
                    hit     = 1'b1;
                    m_owner = k;
                    m_grant = k;
                end
            end
        end else if (req_valid_i[m_owner] && out_rdy) begin
            m_held.push_back(req_data_i[m_owner*DW +: DW]);
            lastb = BURST ? req_last_i[m_owner] : 1'b1;
            if (lastb) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        for (int k = 0; k < N; k++)
            if (req_valid_i[k] && req_ready_o[k]) void'(pq[k].pop_front());
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        fifo_full_i = 1'b0;
        stall       = '0;
        while (pending() && n < 400) begin
            cycle();
            n++;
        end
        chk({tag, "_drain_bound"}, 64'(n < 400), 64'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ready"}, 64'(req_ready_o), 64'd0);
        chk({tag, "_enq"},   64'(fifo_enq_o),  64'd0);
        chk({tag, "_d"},     64'(fifo_d_o),    64'd0);
        chk({tag, "_grant"}, 64'(grant_o),     64'd0);
        chk({tag, "_busy"},  64'(busy_o),      64'd0);
    endtask

    // Asserts reset between clock edges and checks outputs before any edge.
    task automatic reset_pulse(input string tag);
        #2 rst_i = 1'b1;
        #1 check_zero_outputs(tag);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_i = 1'b0;
    endtask

    task automatic expect_stream(input string tag, input int base, input logic [DW-1:0] exp [$]);
        chk({tag, "_count"}, 64'(seen.size() - base), 64'(exp.size()));
        for (int i = 0; i < exp.size() && base + i < seen.size(); i++)
            chk({tag, "_beat"}, 64'(seen[base+i]), 64'(exp[i]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            base;
        int            n;
        logic [DW-1:0] exp [$];
        logic [DW-1:0] tmp;

        rst_i       = 1'b1;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        model_reset();
        @(negedge clk);
        check_zero_outputs("reset");
        rst_i = 1'b0;

        // Single requester, 3-beat packet.
        base = seen.size();
        push(2, 1'b0, 32'hA0);
        push(2, 1'b0, 32'hA1);
        push(2, 1'b1, 32'hA2);
        drain("single");
        exp = '{32'hA0, 32'hA1, 32'hA2};
        expect_stream("single", base, exp);
        if (seen.size() >= base + 3)
            chk("single_spacing", 64'(seen_cyc[base+2] - seen_cyc[base]), BURST ? 64'd2 : 64'd4);

        // Pointer sits at 3 after the packet from requester 2.
        base = seen.size();
        for (int k = 0; k < N; k++) push(k, 1'b1, DW'(32'h30 + k));
        drain("resume");
        exp = '{32'h33, 32'h30, 32'h31, 32'h32};
        expect_stream("resume", base, exp);

        // Fairness: everyone busy with single-beat packets, from reset.
        reset_pulse("rst_a");
        base = seen.size();
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < N; k++) push(k, 1'b1, DW'(32'h100 + k*16 + r));
        drain("fair");
        chk("fair_count", 64'(seen.size() - base), 64'd12);
        for (int i = 0; i < 12 && base + i < seen.size(); i++) begin
            tmp = seen[base+i];
            chk("fair_order", 64'(tmp[7:4]), 64'(i % N));
            if (i > 0) chk("fair_rate", 64'(seen_cyc[base+i] - seen_cyc[base+i-1]), 64'd2);
        end

        // Backpressure: full for 5 cycles during a 4-beat packet.
        base = seen.size();
        for (int b = 0; b < 4; b++) push(1, b == 3, DW'(32'hB0 + b));
        cycle();
        cycle();
        cycle();
        fifo_full_i = 1'b1;
        for (int c = 0; c < 5; c++) cycle();
        drain("bp");
        exp = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        expect_stream("bp", base, exp);

        // Mid-packet stall of requester 1 while requester 0 waits.
        base = seen.size();
        for (int b = 0; b < 3; b++) push(1, b == 2, DW'(32'hC0 + b));
        n = 0;
        while (pq[1].size() != 2 && n < 10) begin
            cycle();
            n++;
        end
        chk("stall_first_beat", 64'(pq[1].size()), 64'd2);
        push(0, 1'b1, 32'hD0);
        stall[1] = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        drain("stall");
        if (BURST) exp = '{32'hC0, 32'hC1, 32'hC2, 32'hD0};
        else       exp = '{32'hC0, 32'hD0, 32'hC1, 32'hC2};
        expect_stream("stall", base, exp);

        // Reset while a beat is held under full: it must be dropped.
        push(3, 1'b0, 32'hE0);
        push(3, 1'b1, 32'hE1);
        cycle();
        cycle();
        fifo_full_i = 1'b1;
        cycle();
        cycle();
        base = seen.size();
        reset_pulse("rst_mid");
        for (int c = 0; c < 4; c++) cycle();
        chk("rst_dropped", 64'(seen.size() - base), 64'd0);
        push(2, 1'b1, 32'hF0);
        push(0, 1'b1, 32'h60);
        drain("after_rst");
        exp = '{32'h60, 32'hF0};
        expect_stream("after_rst", base, exp);

        // Two streaming requesters with multi-beat packets.
        reset_pulse("rst_b");
        base = seen.size();
        for (int b = 0; b < 4; b++) begin
            push(0, b == 3, DW'(32'h70 + b));
            push(1, b == 3, DW'(32'h80 + b));
        end
        drain("stream");
        if (BURST) exp = '{32'h70, 32'h71, 32'h72, 32'h73, 32'h80, 32'h81, 32'h82, 32'h83};
        else       exp = '{32'h70, 32'h80, 32'h71, 32'h81, 32'h72, 32'h82, 32'h73, 32'h83};
        expect_stream("stream", base, exp);

        // Random traffic, stalls and backpressure against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (pq[k].size() == 0 && $urandom_range(0, 3) == 0) begin
                    int len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) push(k, b == len - 1, $urandom);
                end
            end
            stall       = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            fifo_full_i = ($urandom_range(0, 3) == 0);
            cycle();
        end
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
